// File: rtl/rvsteel_bus_pkg.sv
// rvsteel_bus_pkg: bus widths, arbiter state encoding and the per-manager request bundle
// shared by the arbiter and its round-robin picker.
package rvsteel_bus_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = 4;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] address;
      logic                  read;
      logic                  write;
      logic [DATA_WIDTH-1:0] write_data;
      logic [STRB_WIDTH-1:0] write_strobe;
   } mgr_req_t;

   function automatic int unsigned rr_index(int unsigned base, int unsigned offset, int unsigned n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/rvsteel_rr_picker.sv
// rvsteel_rr_picker: combinational round-robin search, first requester at or after pointer.
module rvsteel_rr_picker
   import rvsteel_bus_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     request,
   input  logic [IDX_W-1:0] pointer,
   output logic [IDX_W-1:0] grant,
   output logic             valid
);

   // Walk offsets from far to near so the nearest requester is written last and wins.
   always_comb begin
      grant = '0;
      valid = |request;
      for (int k = N - 1; k >= 0; k--)
         if (request[IDX_W'(rr_index(32'(pointer), k, N))])
            grant = IDX_W'(rr_index(32'(pointer), k, N));
   end

endmodule

// File: rtl/rvsteel_bus_arbiter.sv
// rvsteel_bus_arbiter: round-robin share of the single subordinate port between bus managers,
// one transaction in flight, with a watchdog that answers for a silent subordinate.
module rvsteel_bus_arbiter
   import rvsteel_bus_pkg::*;
#(
   parameter int NUM_MANAGERS   = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NUM_MANAGERS*ADDR_WIDTH-1:0] m_rw_address,
   input  logic [NUM_MANAGERS-1:0]            m_read_request,
   input  logic [NUM_MANAGERS-1:0]            m_write_request,
   input  logic [NUM_MANAGERS*DATA_WIDTH-1:0] m_write_data,
   input  logic [NUM_MANAGERS*STRB_WIDTH-1:0] m_write_strobe,
   output logic [NUM_MANAGERS*DATA_WIDTH-1:0] m_read_data,
   output logic [NUM_MANAGERS-1:0]            m_read_response,
   output logic [NUM_MANAGERS-1:0]            m_write_response,
   output logic [ADDR_WIDTH-1:0]              s_rw_address,
   output logic                               s_read_request,
   output logic                               s_write_request,
   output logic [DATA_WIDTH-1:0]              s_write_data,
   output logic [STRB_WIDTH-1:0]              s_write_strobe,
   input  logic [DATA_WIDTH-1:0]              s_read_data,
   input  logic                               s_read_response,
   input  logic                               s_write_response,
   output logic                               bus_error
);

   localparam int IDX_W = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_MGR   = IDX_W'(NUM_MANAGERS - 1);

   arb_state_t              state, next_state;
   logic [IDX_W-1:0]        owner, rr_pointer, pick;
   logic                    pick_valid, op_read, hit, expired;
   logic [CNT_W-1:0]        count;
   logic [NUM_MANAGERS-1:0] req_vec;
   mgr_req_t                req [NUM_MANAGERS];
   mgr_req_t                sel;

   always_comb
      for (int i = 0; i < NUM_MANAGERS; i++) begin
         req[i].address      = m_rw_address[ADDR_WIDTH*i +: ADDR_WIDTH];
         req[i].read         = m_read_request[i];
         req[i].write        = m_write_request[i];
         req[i].write_data   = m_write_data[DATA_WIDTH*i +: DATA_WIDTH];
         req[i].write_strobe = m_write_strobe[STRB_WIDTH*i +: STRB_WIDTH];
         req_vec[i]          = m_read_request[i] | m_write_request[i];
      end

   rvsteel_rr_picker #(.N(NUM_MANAGERS), .IDX_W(IDX_W)) picker (
      .request (req_vec),
      .pointer (rr_pointer),
      .grant   (pick),
      .valid   (pick_valid)
   );

   always_ff @(posedge clock)
      if (reset) state <= IDLE;
      else       state <= next_state;

   // Every output is gated by reset so nothing leaks while the arbiter is held in reset.
   always_comb begin
      next_state       = state;
      sel              = req[(state == IDLE) ? pick : owner];
      hit              = op_read ? s_read_response : s_write_response;
      expired          = count == LAST_COUNT;
      s_rw_address     = '0;
      s_write_data     = '0;
      s_write_strobe   = '0;
      s_read_request   = 1'b0;
      s_write_request  = 1'b0;
      m_read_data      = '0;
      m_read_response  = '0;
      m_write_response = '0;
      bus_error        = 1'b0;
      if (!reset && (state == BUSY || pick_valid)) begin
         s_rw_address   = sel.address;
         s_write_data   = sel.write_data;
         s_write_strobe = sel.write_strobe;
      end
      if (!reset && state == IDLE && pick_valid) begin
         s_read_request  = sel.read;
         s_write_request = sel.write & ~sel.read;
         next_state      = BUSY;
      end
      if (!reset && state == BUSY && (hit || expired)) begin
         next_state = IDLE;
         bus_error  = ~hit;
         for (int i = 0; i < NUM_MANAGERS; i++)
            if (owner == IDX_W'(i)) begin
               m_read_response[i]                    = op_read;
               m_write_response[i]                   = ~op_read;
               m_read_data[DATA_WIDTH*i +: DATA_WIDTH] = (op_read && hit) ? s_read_data : '0;
            end
      end
   end

   always_ff @(posedge clock)
      if (reset) begin
         owner      <= '0;
         rr_pointer <= '0;
         op_read    <= 1'b0;
         count      <= '0;
      end else if (state == IDLE) begin
         count <= '0;
         if (pick_valid) begin
            owner   <= pick;
            op_read <= sel.read;
         end
      end else begin
         count <= count + 1'b1;
         if (next_state == IDLE)
            rr_pointer <= (owner == LAST_MGR) ? '0 : owner + 1'b1;
      end

endmodule

// File: tb/tb_rvsteel_bus_arbiter.sv
// tb_rvsteel_bus_arbiter: scoreboard bench; stimulus pushes expected issues/completions,
// a monitor pops and compares whenever the arbiter presents a request or response.
module tb_rvsteel_bus_arbiter;

   localparam int NM = 2;
   localparam int TO = 16;

   typedef struct {logic rd; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;} issue_t;
   typedef struct {int mgr; logic rd; logic [31:0] data; logic err; int lat;} comp_t;
   typedef struct {int lat; logic [31:0] data;} plan_t;

   logic             clock = 1'b0, reset = 1'b1;
   logic [NM*32-1:0] m_rw_address = '0, m_write_data = '0, m_read_data;
   logic [NM*4-1:0]  m_write_strobe = '0;
   logic [NM-1:0]    m_read_request = '0, m_write_request = '0, m_read_response, m_write_response;
   logic [31:0]      s_rw_address, s_write_data, s_read_data = '0;
   logic [3:0]       s_write_strobe;
   logic             s_read_request, s_write_request, bus_error;
   logic             s_read_response = 1'b0, s_write_response = 1'b0;

   issue_t issue_q[$];
   comp_t  comp_q[$];
   plan_t  plan_q[$];
   int     checks = 0, fails = 0, cyc = 0, rr = 0, stray_pct = 25;
   logic [31:0] t_addr [NM], t_wdata [NM], t_rdata [NM];
   logic [3:0]  t_strb [NM];
   int          t_op [NM], t_lat [NM];   // op: 0 read, 1 write, 2 both; lat 0 = never answer

   rvsteel_bus_arbiter #(.NUM_MANAGERS(NM), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset),
      .m_rw_address(m_rw_address), .m_read_request(m_read_request), .m_write_request(m_write_request),
      .m_write_data(m_write_data), .m_write_strobe(m_write_strobe), .m_read_data(m_read_data),
      .m_read_response(m_read_response), .m_write_response(m_write_response),
      .s_rw_address(s_rw_address), .s_read_request(s_read_request), .s_write_request(s_write_request),
      .s_write_data(s_write_data), .s_write_strobe(s_write_strobe), .s_read_data(s_read_data),
      .s_read_response(s_read_response), .s_write_response(s_write_response), .bus_error(bus_error)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      fails++;
      $display("FAIL %s: event not allowed by the model (cycle %0d)", name, cyc);
   endtask

   task automatic set_txn(input int i, input int op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int lat, input logic [31:0] rdata);
      t_op[i] = op; t_addr[i] = addr; t_wdata[i] = wdata; t_strb[i] = strb; t_lat[i] = lat; t_rdata[i] = rdata;
   endtask

   // Reference: requesters held until answered are served in index order starting at rr.
   task automatic expect_round(input logic [NM-1:0] set);
      int base, i;
      base = rr;
      for (int k = 0; k < NM; k++) begin
         i = (base + k) % NM;
         if (set[i]) begin
            issue_q.push_back('{t_op[i] != 1, t_addr[i], t_wdata[i], t_strb[i]});
            plan_q.push_back('{t_lat[i], t_rdata[i]});
            comp_q.push_back('{i, t_op[i] != 1, (t_op[i] != 1 && t_lat[i] != 0) ? t_rdata[i] : 32'h0,
                               t_lat[i] == 0, (t_lat[i] == 0) ? TO : t_lat[i]});
            rr = (i + 1) % NM;
         end
      end
   endtask

   task automatic drive(input logic [NM-1:0] set);
      for (int k = 0; k < NM; k++)
         if (set[k]) begin
            m_rw_address[32*k +: 32] = t_addr[k];
            m_write_data[32*k +: 32] = t_wdata[k];
            m_write_strobe[4*k +: 4] = t_strb[k];
            m_read_request[k]        = t_op[k] != 1;
            m_write_request[k]       = t_op[k] != 0;
         end
   endtask

   task automatic idle_check();
      chk("idle_quiet", 64'(|{s_rw_address, s_write_data, s_write_strobe, s_read_request, s_write_request}), 64'h0);
   endtask

   task automatic round(input logic [NM-1:0] set);
      int n;
      expect_round(set);
      drive(set);
      n = 0;
      while ((m_read_request | m_write_request) != 0 && n < 40 * NM) begin
         @(negedge clock);
         n++;
         for (int k = 0; k < NM; k++)
            if (m_read_response[k] | m_write_response[k]) begin
               m_read_request[k]  = 1'b0;
               m_write_request[k] = 1'b0;
            end
      end
      if ((m_read_request | m_write_request) != 0) begin
         flag("round_timeout");
         m_read_request = '0; m_write_request = '0;
         issue_q.delete(); comp_q.delete(); plan_q.delete();
      end
      @(posedge clock); #1;
      idle_check();
   endtask

   initial begin : subordinate
      int rem;
      logic en, rd;
      logic [31:0] data;
      plan_t p;
      rem = 0; en = 1'b0; rd = 1'b0; data = '0;
      forever begin
         @(posedge clock); #1;
         s_read_response = 1'b0; s_write_response = 1'b0; s_read_data = $urandom;
         if (reset) rem = 0;
         else if (rem > 0) begin
            rem--;
            if (rem == 0 && en) begin
               s_read_response = rd; s_write_response = !rd;
               if (rd) s_read_data = data;
            end else if (rem > 0 && $urandom_range(99) < stray_pct) begin
               s_read_response = !rd; s_write_response = rd;
            end
         end else if ($urandom_range(99) < stray_pct) begin
            if ($urandom_range(1) == 1) s_read_response = 1'b1;
            else s_write_response = 1'b1;
         end
         @(negedge clock);
         if (!reset && (s_read_request || s_write_request) && plan_q.size() > 0) begin
            p = plan_q.pop_front();
            rd = s_read_request; en = p.lat != 0; rem = en ? p.lat : TO; data = p.data;
         end
      end
   end

   initial begin : monitor
      logic prev_rst;
      int issue_cyc;
      issue_t ie;
      comp_t ce;
      logic [NM-1:0] resp;
      prev_rst = 1'b0; issue_cyc = 0;
      forever begin
         @(negedge clock);
         resp = m_read_response | m_write_response;
         if (reset) begin
            if (prev_rst)
               chk("reset_quiet", 64'(|{s_rw_address, s_write_data, s_write_strobe, s_read_request, s_write_request,
                                         m_read_data, m_read_response, m_write_response, bus_error}), 64'h0);
         end else begin
            if (s_read_request || s_write_request) begin
               if (issue_q.size() == 0) flag("unexpected_issue");
               else begin
                  ie = issue_q.pop_front();
                  chk("issue_kind", {s_read_request, s_write_request}, {ie.rd, !ie.rd});
                  chk("issue_addr", s_rw_address, ie.addr);
                  chk("issue_wdata", s_write_data, ie.wdata);
                  chk("issue_strb", s_write_strobe, ie.strb);
                  issue_cyc = cyc;
               end
            end
            if (resp != 0) begin
               if (comp_q.size() == 0) flag("unexpected_response");
               else begin
                  ce = comp_q.pop_front();
                  chk("resp_owner", resp, NM'(1) << ce.mgr);
                  chk("resp_kind", {m_read_response[ce.mgr], m_write_response[ce.mgr]}, {ce.rd, !ce.rd});
                  chk("resp_data", m_read_data[32*ce.mgr +: 32], ce.data);
                  chk("bus_error", bus_error, ce.err);
                  chk("resp_latency", cyc - issue_cyc, ce.lat);
               end
            end else chk("bus_error_quiet", bus_error, 1'b0);
            for (int i = 0; i < NM; i++)
               if (!m_read_response[i]) chk("read_data_zero", m_read_data[32*i +: 32], 32'h0);
         end
         prev_rst = reset;
      end
   end

   initial begin : stimulus
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      idle_check();
      set_txn(0, 0, 32'h0000_1000, 32'h0, 4'h0, 1, 32'h1111_0000);
      set_txn(1, 0, 32'h0000_2000, 32'h0, 4'h0, 3, 32'h2222_0000);
      round(2'b11);
      set_txn(0, 1, 32'h0000_1004, 32'hA5A5_A5A5, 4'hF, 2, 32'h0);
      set_txn(1, 0, 32'h0000_2004, 32'h0, 4'h0, 1, 32'h2222_0004);
      round(2'b11);
      set_txn(0, 0, 32'h0000_0010, 32'h0, 4'h0, 1, 32'hDEAD_BEEF);
      round(2'b01);
      set_txn(1, 1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 1, 32'h0);
      set_txn(0, 0, 32'h0000_0200, 32'h0, 4'h0, 2, 32'h0BAD_CAFE);
      round(2'b11);
      set_txn(0, 0, 32'h0000_0300, 32'h0, 4'h0, 0, 32'h0);
      round(2'b01);
      stray_pct = 90;
      set_txn(0, 2, 32'h0000_0040, 32'h7777_7777, 4'h5, 4, 32'hCAFE_F00D);
      round(2'b01);
      stray_pct = 25;
      set_txn(0, 0, 32'h0000_0500, 32'h0, 4'h0, 1, 32'h5555_0000);
      set_txn(1, 0, 32'h0000_0600, 32'h0, 4'h0, 0, 32'h6666_0000);
      expect_round(2'b11);
      drive(2'b11);
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      issue_q.delete(); comp_q.delete(); plan_q.delete();
      rr = 0;
      m_read_request = '0; m_write_request = '0;
      reset = 1'b0;
      idle_check();
      set_txn(0, 0, 32'h0000_0700, 32'h0, 4'h0, 2, 32'h7070_7070);
      set_txn(1, 1, 32'h0000_0800, 32'h8080_8080, 4'hC, 1, 32'h0);
      round(2'b11);
      repeat (80) begin
         for (int i = 0; i < NM; i++)
            set_txn(i, $urandom_range(2), $urandom, $urandom, 4'($urandom_range(15)),
                    ($urandom_range(7) == 0) ? 0 : $urandom_range(4, 1), $urandom);
         round(NM'($urandom_range(2**NM - 1, 1)));
      end
      repeat (3) @(posedge clock);
      if (issue_q.size() != 0 || comp_q.size() != 0) flag("leftover_expectations");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/rvsteel_bus_arbiter.md
Name: rvsteel_bus_arbiter

Overview:
- Shares the single SoC memory/peripheral subordinate port between NUM_MANAGERS bus managers. Manager 0 is the rvsteel core; manager 1 is the planned UART boot-loader/DMA.
- Sits between the managers and the address decoder inside rvsteel_soc.
- Round-robin arbitration, one outstanding transaction at a time, with a response watchdog so a silent subordinate cannot hang the bus.

Parameters:
NUM_MANAGERS, 2, number of requesting managers (2..4)
TIMEOUT_CYCLES, 16, cycles to wait for a subordinate response before forcing an error response (>=2)

Ports:
clock  input  1  system clock, single clock domain; all logic on rising edge
reset  input  1  synchronous, active-high reset
m_rw_address  input  NUM_MANAGERS*32  per-manager address, manager i at [32*i+:32]
m_read_request  input  NUM_MANAGERS  per-manager read request
m_write_request  input  NUM_MANAGERS  per-manager write request
m_write_data  input  NUM_MANAGERS*32  per-manager write data
m_write_strobe  input  NUM_MANAGERS*4  per-manager byte strobes
m_read_data  output  NUM_MANAGERS*32  read data returned to each manager
m_read_response  output  NUM_MANAGERS  read completion, owner only
m_write_response  output  NUM_MANAGERS  write completion, owner only
s_rw_address  output  32  address to subordinate
s_read_request  output  1  one-cycle read request pulse to subordinate
s_write_request  output  1  one-cycle write request pulse to subordinate
s_write_data  output  32  write data to subordinate
s_write_strobe  output  4  strobes to subordinate
s_read_data  input  32  subordinate read data
s_read_response  input  1  subordinate read completion
s_write_response  input  1  subordinate write completion
bus_error  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Request definition: manager i requests when m_read_request[i] | m_write_request[i]. A manager holds its request, address, data and strobe stable until it sees its response.
- FSM states are IDLE and BUSY. Registered state: owner index, rr_pointer, latched op (read/write), timeout counter.
- IDLE:
  - If any request is present, grant the first requester at or after rr_pointer, searching in increasing index modulo NUM_MANAGERS.
  - In the same cycle, drive s_* from the granted manager and pulse s_read_request or s_write_request for exactly one cycle (zero added latency). Move to BUSY with the counter at 0.
  - If a manager asserts both read and write requests, the read is issued and the write ignored.
- BUSY:
  - s_rw_address, s_write_data and s_write_strobe continue to mirror the owner.
  - s_*_request is 0.
  - The counter increments each cycle.
- Completion:
  - When s_read_response or s_write_response matches the latched op, route it and s_read_data to the owner's m_* for that cycle.
  - Set rr_pointer to (owner+1) mod NUM_MANAGERS and return to IDLE.
  - A new grant can occur on the next cycle, so sustained throughput is one transaction per 2 cycles when the subordinate responds in 1 cycle.
- Mismatched response: a response that does not match the latched op is ignored.
- Watchdog: when the counter reaches TIMEOUT_CYCLES-1 with no response:
  - Assert the owner's matching m_*_response with m_read_data = 32'h0.
  - Pulse bus_error.
  - Advance rr_pointer and return to IDLE.
- Non-owners always see m_*_response = 0 and m_read_data = 0.
- A response arriving in IDLE is dropped.
- Reset (any cycle, including mid-transaction):
  - State goes to IDLE, rr_pointer to 0, counter to 0.
  - All s_* and m_* outputs and bus_error go to 0 in the cycle after reset is sampled, and stay 0 while reset is high.
  - An in-flight transaction is abandoned, with no response to its manager.
- Simultaneous requests: the round-robin pointer guarantees each requester is served within NUM_MANAGERS transactions.
- Idle outputs: in IDLE with no request, s_* outputs are 0.

Decomposition:
- Package rvsteel_bus_pkg holds:
  - localparams ADDR_WIDTH=32, DATA_WIDTH=32, STRB_WIDTH=4.
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - A packed struct bundling one manager's request fields.
- Sub-module rvsteel_rr_picker (combinational): takes the request vector and rr_pointer, returns the grant index and a valid flag. It is reusable for future interrupt arbitration.

Test Plan:
- Single read: m0 reads 0x0000_0010 and the subordinate model responds after 1 cycle with 0xDEADBEEF -> s_read_request pulses once; m_read_response[0]=1 with data 0xDEADBEEF exactly 1 cycle after the grant; m1 sees nothing.
- Contention: m0 and m1 both request at reset release -> m0 is served first, then m1 on the following grant; a subsequent simultaneous request is served m1-side first only if rr_pointer points to it (the grant order is 0,1,0,1 over 4 transactions).
- Write routing: m1 writes 0x1234_5678 with strobe 4'b0011 to 0x0000_0100 -> s_write_data, s_write_strobe and s_rw_address match; m_write_response[1] pulses; m0 is stalled until then.
- Timeout: the subordinate never responds to an m0 read -> after 16 cycles m_read_response[0]=1 with data 0, bus_error pulses once, and the FSM is back in IDLE.
- Reset mid-transaction: assert reset 2 cycles into BUSY -> no response is delivered, outputs are 0, and the next m1 request is granted per rr_pointer=0 ordering.
- Stray response: pulse s_read_response while IDLE, and s_write_response during a read -> both are ignored; the read still completes correctly.
